bitwise_reduce_pipe: RTL and testbench
======================================

Name: bitwise_reduce_pipe

Overview:
- Parametrised successor of the fixed 2-input, 4-bit AND wrapper.
- Bitwise-reduces N operands of WIDTH bits using a runtime-selected op (AND/OR/XOR/NAND).
- Two-stage pipeline with valid/ready handshake on both sides; one result per cycle at full throughput.
- Sits between mantle logic primitives and streaming datapaths that need backpressure.

Parameters:
- WIDTH, 4, bit width of each operand and of the result (>=1).
- N, 2, number of operands (1..8).

Ports:
- CLK  input  1  clock, rising edge.
- ASYNCRESET  input  1  asynchronous, active-high reset.
- I  input  N*WIDTH  operands; operand k = I[k*WIDTH +: WIDTH].
- OP  input  2  00 AND, 01 OR, 10 XOR, 11 NAND; sampled with I.
- I_VALID  input  1  input beat valid.
- I_READY  output  1  block can accept a beat this cycle.
- O  output  WIDTH  reduction result.
- O_VALID  output  1  O holds a valid result.
- O_READY  input  1  downstream accepts O this cycle.

Behaviour:
- Transfer on a port occurs when its valid and ready are both high at a CLK rising edge.
- Stage 1 (S1) registers lo = reduce(operands 0..ceil(N/2)-1), hi = reduce(remaining operands), plus OP and s1_valid.
  - Reduction uses AND for OP 00/11, OR for 01, XOR for 10.
  - Empty hi half (N=1) takes the identity value: all-ones for AND/NAND, zero for OR/XOR.
- Stage 2 (S2) registers O = combine(lo, hi), inverted when OP=11, plus O_VALID.
- Latency: accepted beat appears on O exactly 2 cycles later when not stalled.
- Advance rules:
  - s2_en = !O_VALID || O_READY.
  - s1_en = !s1_valid || s2_en.
  - I_READY = s1_en (combinational from O_READY; no skid buffer).
- S2 loads S1 contents when s2_en. O_VALID next = s1_valid when s2_en, else holds.
- S1 loads inputs when s1_en. s1_valid next = I_VALID when s1_en, else holds.
- While stalled, O and O_VALID are held stable; O must not change while O_VALID && !O_READY.
- Simultaneous input accept and output consume in the same cycle are both honoured; full throughput is 1 beat/cycle.
- Data registers are not gated by valid; only valid bits matter.
- Reset values (async assert): s1_valid=0, O_VALID=0, O=0, S1 data=0, I_READY=1 after reset.
- Reset mid-operation drops all in-flight beats; no output is produced for them.
- OP is per-beat; mixed ops back-to-back are legal.

Optional Feature:
- Macro: BITWISE_REDUCE_PIPE_STICKY_EN.
- With macro defined:
  - Extra ports STICKY_CLR input 1 and O_STICKY output WIDTH.
  - O_STICKY accumulates the OR of O over every output transfer since reset or last clear.
  - STICKY_CLR has priority; a transfer in the same cycle as clear leaves O_STICKY = that beat's O.
  - Reset value of O_STICKY is 0.
- Without macro: ports and register are absent; behaviour is otherwise identical.

Decomposition:
- Package bitwise_reduce_pkg holds:
  - the OP encoding constants (OP_AND, OP_OR, OP_XOR, OP_NAND);
  - an identity-value function of (op, WIDTH);
  - a combine function (op, a, b).
- One sub-module, bitwise_reduce_tree: combinational, parametrised by count M and WIDTH; reduces M operands by the package op. Instantiated twice, for the lo and hi halves.

Test Plan:
- WIDTH=4, N=2: I={4'b1010,4'b1100}, OP=00, I_VALID one cycle, O_READY=1 -> O=4'b1000, O_VALID high exactly 2 cycles after accept, 1 cycle wide.
- Same operands, consecutive beats with OP=01,10,11 -> O=1110, 0110, 0111 on consecutive cycles; I_READY stays 1.
- N=3, WIDTH=8: operands 8'hF0, 8'h3C, 8'h0F, OP=10 -> O=8'hC3. N=1: OP=11, operand 8'h5A -> O=8'hA5.
- Backpressure: stream 4 beats, O_READY=0 for 3 cycles -> I_READY drops after 2 beats buffered; O stable; all 4 results delivered in order, none lost or duplicated.
- Assert ASYNCRESET between clock edges with 2 beats in flight -> O_VALID=0 and O=0 immediately; no stale output after release.
- STICKY_EN build: results 0001 then 0100 -> O_STICKY=0101; STICKY_CLR with concurrent result 1000 -> O_STICKY=1000.

Source files
------------

// File: rtl/bitwise_reduce_pkg.sv
// Shared op encoding and helper functions for the bitwise reduction pipeline.
// Functions work on MAX_W-bit vectors; callers size-cast to their own width.
package bitwise_reduce_pkg;

    localparam int MAX_W = 64;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

    // NAND reduces with AND; the final inversion happens once, at the output stage.
    function automatic logic [MAX_W-1:0] identity(input logic [1:0] op, input int unsigned width);
        logic [MAX_W-1:0] v;
        v = '0;
        if (op == OP_AND || op == OP_NAND) begin
            for (int unsigned b = 0; b < MAX_W; b++) begin
                if (b < width) v[b] = 1'b1;
            end
        end
        return v;
    endfunction

    function automatic logic [MAX_W-1:0] combine(input logic [1:0] op,
                                                 input logic [MAX_W-1:0] a,
                                                 input logic [MAX_W-1:0] b);
        logic [MAX_W-1:0] r;
        case (op)
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            default: r = a & b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/bitwise_reduce_tree.sv
// Combinational reduction of M operands of WIDTH bits; M=0 yields the op identity.
module bitwise_reduce_tree
    import bitwise_reduce_pkg::*;
#(
    parameter int M     = 1,
    parameter int WIDTH = 4
) (
    input  logic [((M > 0) ? M : 1)*WIDTH-1:0] d_i,
    input  logic [1:0]                         op_i,
    output logic [WIDTH-1:0]                   r_o
);

    logic [WIDTH-1:0] acc;

    always_comb begin
        acc = WIDTH'(identity(op_i, WIDTH));
        for (int k = 0; k < M; k++) begin
            acc = WIDTH'(combine(op_i, MAX_W'(acc), MAX_W'(d_i[k*WIDTH +: WIDTH])));
        end
    end

    assign r_o = acc;

endmodule

// File: rtl/bitwise_reduce_pipe.sv
// Two-stage bitwise reduce (AND/OR/XOR/NAND) of N operands with valid/ready on both sides.
// Optional BITWISE_REDUCE_PIPE_STICKY_EN adds an OR-accumulator of delivered results.
module bitwise_reduce_pipe
    import bitwise_reduce_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int N     = 2
) (
    input  logic               CLK,
    input  logic               ASYNCRESET,
    input  logic [N*WIDTH-1:0] I,
    input  logic [1:0]         OP,
    input  logic               I_VALID,
    output logic               I_READY,
    output logic [WIDTH-1:0]   O,
    output logic               O_VALID,
    input  logic               O_READY
`ifdef BITWISE_REDUCE_PIPE_STICKY_EN
    ,
    input  logic               STICKY_CLR,
    output logic [WIDTH-1:0]   O_STICKY
`endif
);

    localparam int N_LO = (N + 1) / 2;
    localparam int N_HI = N - N_LO;
    localparam int HI_W = ((N_HI > 0) ? N_HI : 1) * WIDTH;

    logic [HI_W-1:0]  hi_in;
    logic [WIDTH-1:0] lo_r, hi_r;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_lo_q, s1_lo_d;
    logic [WIDTH-1:0] s1_hi_q, s1_hi_d;
    logic [1:0]       s1_op_q, s1_op_d;
    logic [WIDTH-1:0] o_q, o_d;
    logic             o_valid_q, o_valid_d;
    logic [WIDTH-1:0] s2_comb;
    logic             s1_en, s2_en;

    generate
        if (N_HI > 0) begin : g_hi
            assign hi_in = I[N*WIDTH-1 : N_LO*WIDTH];
        end else begin : g_no_hi
            assign hi_in = '0;
        end
    endgenerate

    bitwise_reduce_tree #(.M(N_LO), .WIDTH(WIDTH)) u_lo (
        .d_i  (I[N_LO*WIDTH-1:0]),
        .op_i (OP),
        .r_o  (lo_r)
    );

    bitwise_reduce_tree #(.M(N_HI), .WIDTH(WIDTH)) u_hi (
        .d_i  (hi_in),
        .op_i (OP),
        .r_o  (hi_r)
    );

    // Handshake: a beat moves on a side when valid && ready at a rising CLK edge.
    // A stage advances when it is empty or the stage after it advances; I_READY is
    // therefore combinational from O_READY and there is no skid buffer.
    assign s2_en   = !o_valid_q || O_READY;
    assign s1_en   = !s1_valid_q || s2_en;
    assign I_READY = s1_en;

    assign s2_comb = WIDTH'(combine(s1_op_q, MAX_W'(s1_lo_q), MAX_W'(s1_hi_q)));

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_lo_d    = s1_lo_q;
        s1_hi_d    = s1_hi_q;
        s1_op_d    = s1_op_q;
        o_valid_d  = o_valid_q;
        o_d        = o_q;
        if (s1_en) begin
            s1_valid_d = I_VALID;
            s1_lo_d    = lo_r;
            s1_hi_d    = hi_r;
            s1_op_d    = OP;
        end
        if (s2_en) begin
            o_valid_d = s1_valid_q;
            o_d       = (s1_op_q == OP_NAND) ? ~s2_comb : s2_comb;
        end
    end

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            s1_valid_q <= 1'b0;
            s1_lo_q    <= '0;
            s1_hi_q    <= '0;
            s1_op_q    <= '0;
            o_valid_q  <= 1'b0;
            o_q        <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_lo_q    <= s1_lo_d;
            s1_hi_q    <= s1_hi_d;
            s1_op_q    <= s1_op_d;
            o_valid_q  <= o_valid_d;
            o_q        <= o_d;
        end
    end

    assign O       = o_q;
    assign O_VALID = o_valid_q;

`ifdef BITWISE_REDUCE_PIPE_STICKY_EN
    logic [WIDTH-1:0] sticky_q, sticky_d;
    logic             o_xfer;

    assign o_xfer = o_valid_q && O_READY;

    // Clear wins, but a result leaving in the same cycle still lands in the fresh value.
    always_comb begin
        sticky_d = sticky_q;
        if (STICKY_CLR) begin
            sticky_d = o_xfer ? o_q : '0;
        end else if (o_xfer) begin
            sticky_d = sticky_q | o_q;
        end
    end

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) sticky_q <= '0;
        else            sticky_q <= sticky_d;
    end

    assign O_STICKY = sticky_q;
`endif

endmodule

// File: tb/tb_bitwise_reduce_pipe.sv
// Directed bench for bitwise_reduce_pipe: N=2/W=4 main instance plus N=3 and N=1 W=8 instances.
module tb_bitwise_reduce_pipe;

    logic       clk;
    logic       rst;

    logic [7:0] din;
    logic [1:0] op;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] o;
    logic       o_valid;
    logic       o_ready;

    logic [23:0] din3;
    logic [1:0]  op3;
    logic        in_valid3, in_ready3;
    logic [7:0]  o3;
    logic        o_valid3;

    logic [7:0]  din1;
    logic [1:0]  op1;
    logic        in_valid1, in_ready1;
    logic [7:0]  o1;
    logic        o_valid1;

`ifdef BITWISE_REDUCE_PIPE_STICKY_EN
    logic        sticky_clr, sticky_clr3, sticky_clr1;
    logic [3:0]  o_sticky;
    logic [7:0]  o_sticky3, o_sticky1;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [3:0] exp_q[$];

    bitwise_reduce_pipe #(.WIDTH(4), .N(2)) u_dut (
        .CLK(clk), .ASYNCRESET(rst), .I(din), .OP(op), .I_VALID(in_valid), .I_READY(in_ready),
        .O(o), .O_VALID(o_valid), .O_READY(o_ready)
`ifdef BITWISE_REDUCE_PIPE_STICKY_EN
        , .STICKY_CLR(sticky_clr), .O_STICKY(o_sticky)
`endif
    );

    bitwise_reduce_pipe #(.WIDTH(8), .N(3)) u_dut3 (
        .CLK(clk), .ASYNCRESET(rst), .I(din3), .OP(op3), .I_VALID(in_valid3), .I_READY(in_ready3),
        .O(o3), .O_VALID(o_valid3), .O_READY(1'b1)
`ifdef BITWISE_REDUCE_PIPE_STICKY_EN
        , .STICKY_CLR(sticky_clr3), .O_STICKY(o_sticky3)
`endif
    );

    bitwise_reduce_pipe #(.WIDTH(8), .N(1)) u_dut1 (
        .CLK(clk), .ASYNCRESET(rst), .I(din1), .OP(op1), .I_VALID(in_valid1), .I_READY(in_ready1),
        .O(o1), .O_VALID(o_valid1), .O_READY(1'b1)
`ifdef BITWISE_REDUCE_PIPE_STICKY_EN
        , .STICKY_CLR(sticky_clr1), .O_STICKY(o_sticky1)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // driver: present one beat on the main instance and wait (bounded) for acceptance
    task automatic send(input logic [7:0] d, input logic [1:0] opv, input logic [3:0] expv);
        int k;
        din      = d;
        op       = opv;
        in_valid = 1'b1;
        k        = 0;
        @(negedge clk);
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) check("send_ready", 64'(in_ready), 64'd1);
        else           exp_q.push_back(expv);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // scoreboard: every delivered result must match the oldest expected value
    always @(negedge clk) begin
        if (!rst && o_valid && o_ready) begin
            if (exp_q.size() == 0) check("extra_output", 64'(exp_q.size()), 64'd1);
            else                   check("out_data", 64'(o), 64'(exp_q.pop_front()));
        end
    end

    logic [3:0] hold_o;
    logic [7:0] side_ops [4];
    logic [7:0] exp3 [4];
    logic [7:0] exp1 [4];

    initial begin
        rst = 1'b1;
        din = '0; op = '0; in_valid = 1'b0; o_ready = 1'b1;
        din3 = '0; op3 = '0; in_valid3 = 1'b0;
        din1 = '0; op1 = '0; in_valid1 = 1'b0;
`ifdef BITWISE_REDUCE_PIPE_STICKY_EN
        sticky_clr = 1'b0; sticky_clr3 = 1'b0; sticky_clr1 = 1'b0;
`endif
        side_ops = '{8'd0, 8'd1, 8'd2, 8'd3};
        exp3     = '{8'h00, 8'hFF, 8'hC3, 8'hFF};
        exp1     = '{8'h5A, 8'h5A, 8'h5A, 8'hA5};

        #12;
        check("rst_o_valid", 64'(o_valid), 64'd0);
        check("rst_o", 64'(o), 64'd0);
        check("rst_i_ready", 64'(in_ready), 64'd1);
`ifdef BITWISE_REDUCE_PIPE_STICKY_EN
        check("rst_sticky", 64'(o_sticky), 64'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // AND beat: latency 2 cycles, valid pulse 1 cycle wide
        din = {4'b1010, 4'b1100}; op = 2'b00; in_valid = 1'b1;
        @(negedge clk);
        check("lat_i_ready", 64'(in_ready), 64'd1);
        exp_q.push_back(4'b1000);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("lat_c1_valid", 64'(o_valid), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("lat_c2_valid", 64'(o_valid), 64'd1);
        check("lat_c2_data", 64'(o), 64'b1000);
        @(posedge clk); #1;
        @(negedge clk);
        check("lat_pulse_end", 64'(o_valid), 64'd0);
        @(posedge clk); #1;

        // back-to-back OR / XOR / NAND at full throughput
        din = {4'b1010, 4'b1100};
        for (int i = 0; i < 3; i++) begin
            op       = 2'(i + 1);
            in_valid = 1'b1;
            @(negedge clk);
            check("thru_i_ready", 64'(in_ready), 64'd1);
            case (i)
                0:       exp_q.push_back(4'b1110);
                1:       exp_q.push_back(4'b0110);
                default: exp_q.push_back(4'b0111);
            endcase
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        check("thru_drained", 64'(exp_q.size()), 64'd0);

        // backpressure: two beats fill the pipe, third must wait
        o_ready = 1'b0;
        send({4'h5, 4'h3}, 2'b00, 4'b0001);
        send({4'h5, 4'h3}, 2'b01, 4'b0111);
        @(negedge clk);
        check("bp_i_ready_low", 64'(in_ready), 64'd0);
        check("bp_o_valid", 64'(o_valid), 64'd1);
        check("bp_o_first", 64'(o), 64'b0001);
        hold_o = o;
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_o_stable", 64'(o), 64'(hold_o));
        check("bp_i_ready_still_low", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        o_ready = 1'b1;
        send({4'h5, 4'h3}, 2'b10, 4'b0110);
        send({4'h5, 4'h3}, 2'b11, 4'b1110);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        check("bp_drained", 64'(exp_q.size()), 64'd0);

        // async reset between edges with two beats in flight
        send(8'hFF, 2'b01, 4'b1111);
        din = 8'h00; op = 2'b10; in_valid = 1'b1;
        @(posedge clk); #1;
        check("rst_pre_valid", 64'(o_valid), 64'd1);
        #1;
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        check("rst_mid_o_valid", 64'(o_valid), 64'd0);
        check("rst_mid_o", 64'(o), 64'd0);
        check("rst_mid_i_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_no_stale", 64'(o_valid), 64'd0);
        end
        @(posedge clk); #1;

        // N=3 and N=1 instances, all four ops; N=1 exercises the empty hi half
        din3 = {8'h0F, 8'h3C, 8'hF0};
        din1 = 8'h5A;
        for (int i = 0; i < 4; i++) begin
            op3 = side_ops[i][1:0];
            op1 = side_ops[i][1:0];
            in_valid3 = 1'b1;
            in_valid1 = 1'b1;
            @(posedge clk); #1;
            in_valid3 = 1'b0;
            in_valid1 = 1'b0;
            @(posedge clk);
            @(negedge clk);
            check("n3_valid", 64'(o_valid3), 64'd1);
            check("n3_data", 64'(o3), 64'(exp3[i]));
            check("n1_valid", 64'(o_valid1), 64'd1);
            check("n1_data", 64'(o1), 64'(exp1[i]));
            @(posedge clk); #1;
        end

`ifdef BITWISE_REDUCE_PIPE_STICKY_EN
        // sticky accumulation then clear with a concurrent result
        send({4'h5, 4'h3}, 2'b00, 4'b0001);
        send({4'h4, 4'h4}, 2'b00, 4'b0100);
        repeat (3) @(posedge clk);
        #1;
        check("sticky_acc", 64'(o_sticky), 64'b0101);
        send({4'b1010, 4'b1100}, 2'b00, 4'b1000);
        begin
            int k;
            k = 0;
            @(negedge clk);
            while (!o_valid && k < 20) begin
                @(negedge clk);
                k++;
            end
            check("sticky_wait_valid", 64'(o_valid), 64'd1);
        end
        sticky_clr = 1'b1;
        @(posedge clk); #1;
        sticky_clr = 1'b0;
        check("sticky_clr_xfer", 64'(o_sticky), 64'b1000);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("final_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
